// File: rtl/bram_arbiter.sv
// Two-client round-robin arbiter in front of a dual-port BRAM, with a
// sweep engine that overwrites every word with CLEAR_VALUE on request.
module bram_arbiter #(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 32,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int              AW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_start,
    output logic             clear_busy,
    output logic             clear_done,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [WIDTH-1:0] b_rdata,
    output logic             mem_write_enable,
    output logic [AW-1:0]    mem_addr_write,
    output logic [AW-1:0]    mem_addr_read,
    output logic [WIDTH-1:0] mem_data_in,
    input  logic [WIDTH-1:0] mem_data_out
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t          state_q;
    logic [AW-1:0]   sweep_q;
    logic [AW-1:0]   raddr_q;
    logic [AW-1:0]   raddr_d;
    logic            prio_q;
    logic            done_q;
    logic            a_rvalid_q;
    logic            b_rvalid_q;
    logic            idle;

    // prio_q = 0 favours A on contention, 1 favours B.
    always_comb begin
        idle  = (state_q == IDLE) && !reset;
        a_gnt = idle && a_req && (!b_req || !prio_q);
        b_gnt = idle && b_req && (!a_req || prio_q);

        mem_write_enable = 1'b0;
        mem_addr_write   = sweep_q;
        mem_data_in      = CLEAR_VALUE;
        raddr_d          = raddr_q;

        if (state_q == CLEAR) begin
            mem_write_enable = !reset;
        end else if (a_gnt) begin
            if (a_we) begin
                mem_write_enable = 1'b1;
                mem_addr_write   = a_addr;
                mem_data_in      = a_wdata;
            end else begin
                raddr_d = a_addr;
            end
        end else if (b_gnt) begin
            if (b_we) begin
                mem_write_enable = 1'b1;
                mem_addr_write   = b_addr;
                mem_data_in      = b_wdata;
            end else begin
                raddr_d = b_addr;
            end
        end

        mem_addr_read = reset ? '0 : raddr_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sweep_q    <= '0;
            raddr_q    <= '0;
            prio_q     <= 1'b0;
            done_q     <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            raddr_q    <= raddr_d;
            a_rvalid_q <= a_gnt && !a_we;
            b_rvalid_q <= b_gnt && !b_we;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (a_gnt) begin
                        prio_q <= 1'b1;
                    end else if (b_gnt) begin
                        prio_q <= 1'b0;
                    end
                    if (clear_start) begin
                        state_q <= CLEAR;
                        sweep_q <= '0;
                    end
                end
                CLEAR: begin
                    if (sweep_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        sweep_q <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        sweep_q <= sweep_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clear_busy = (state_q == CLEAR);
    assign clear_done = done_q;
    assign a_rvalid   = a_rvalid_q;
    assign b_rvalid   = b_rvalid_q;
    assign a_rdata    = mem_data_out;
    assign b_rdata    = mem_data_out;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: arbitration, read/write paths, clear
// sweep, reset abort, and clear started alongside a read.
module tb_bram_arbiter;

    localparam int WIDTH = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             clearStart;
    logic             clearBusy;
    logic             clearDone;
    logic             aReq, aWe, aGnt, aRvalid;
    logic [AW-1:0]    aAddr;
    logic [WIDTH-1:0] aWdata, aRdata;
    logic             bReq, bWe, bGnt, bRvalid;
    logic [AW-1:0]    bAddr;
    logic [WIDTH-1:0] bWdata, bRdata;
    logic             memWe;
    logic [AW-1:0]    memAddrWrite, memAddrRead;
    logic [WIDTH-1:0] memDataIn, memDataOut;

    logic [WIDTH-1:0] ram [DEPTH];

    int checkCount = 0;
    int failCount  = 0;
    logic doneSeen;

    always #5 clk = ~clk;

    // Simple dual-port RAM with one cycle registered read latency.
    always @(posedge clk) begin
        if (memWe) ram[memAddrWrite] <= memDataIn;
        memDataOut <= ram[memAddrRead];
    end

    bram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLEAR_VALUE(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .clear_start(clearStart), .clear_busy(clearBusy), .clear_done(clearDone),
        .a_req(aReq), .a_we(aWe), .a_addr(aAddr), .a_wdata(aWdata),
        .a_gnt(aGnt), .a_rvalid(aRvalid), .a_rdata(aRdata),
        .b_req(bReq), .b_we(bWe), .b_addr(bAddr), .b_wdata(bWdata),
        .b_gnt(bGnt), .b_rvalid(bRvalid), .b_rdata(bRdata),
        .mem_write_enable(memWe), .mem_addr_write(memAddrWrite),
        .mem_addr_read(memAddrRead), .mem_data_in(memDataIn),
        .mem_data_out(memDataOut)
    );

    task automatic applyStimulus(input logic ar, input logic aw, input logic [AW-1:0] aa,
                                 input logic [WIDTH-1:0] ad, input logic br, input logic bw,
                                 input logic [AW-1:0] ba, input logic [WIDTH-1:0] bd,
                                 input logic cs);
        @(negedge clk);
        aReq = ar; aWe = aw; aAddr = aa; aWdata = ad;
        bReq = br; bWe = bw; bAddr = ba; bWdata = bd;
        clearStart = cs;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        aReq = 0; aWe = 0; aAddr = '0; aWdata = '0;
        bReq = 0; bWe = 0; bAddr = '0; bWdata = '0;
        clearStart = 0;
        doReset();

        idleCycle();
        checkOutput("rst_busy", clearBusy, 0);
        checkOutput("rst_done", clearDone, 0);
        checkOutput("rst_arvalid", aRvalid, 0);
        checkOutput("rst_brvalid", bRvalid, 0);
        checkOutput("rst_we", memWe, 0);
        checkOutput("rst_raddr", memAddrRead, 0);

        // Lone write then read-back of the same address
        applyStimulus(1, 1, 5'd5, 16'hBEEF, 0, 0, '0, '0, 0);
        checkOutput("wr_agnt", aGnt, 1);
        checkOutput("wr_bgnt", bGnt, 0);
        checkOutput("wr_we", memWe, 1);
        checkOutput("wr_waddr", memAddrWrite, 5);
        checkOutput("wr_din", memDataIn, 16'hBEEF);
        applyStimulus(1, 0, 5'd5, '0, 0, 0, '0, '0, 0);
        checkOutput("rd_agnt", aGnt, 1);
        checkOutput("rd_we", memWe, 0);
        checkOutput("rd_raddr", memAddrRead, 5);
        idleCycle();
        checkOutput("rd_arvalid", aRvalid, 1);
        checkOutput("rd_ardata", aRdata, 16'hBEEF);
        checkOutput("rd_brvalid", bRvalid, 0);
        checkOutput("rd_raddr_hold", memAddrRead, 5);
        idleCycle();
        checkOutput("rd_arvalid_once", aRvalid, 0);

        // Contention straight after reset alternates A, B, A, B
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 5'd1, '0, 1, 0, 5'd2, '0, 0);
            checkOutput($sformatf("rr%0d_agnt", i), aGnt, (i % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("rr%0d_bgnt", i), bGnt, (i % 2 == 1) ? 1 : 0);
        end
        applyStimulus(0, 0, '0, '0, 1, 0, 5'd3, '0, 0);
        checkOutput("lone_b_gnt", bGnt, 1);
        checkOutput("lone_b_agnt", aGnt, 0);

        // Preload, then a full sweep with A requesting throughout
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1, 5'(i), 16'h1234, 0, 0, '0, '0, 0);
        applyStimulus(1, 0, 5'd17, '0, 0, 0, '0, '0, 0);
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 1);
        checkOutput("pre_arvalid", aRvalid, 1);
        checkOutput("pre_ardata", aRdata, 16'h1234);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 0, 5'd0, '0, 0, 0, '0, '0, (i == 10) ? 1'b1 : 1'b0);
            checkOutput($sformatf("clr%0d_busy", i), clearBusy, 1);
            checkOutput($sformatf("clr%0d_agnt", i), aGnt, 0);
            checkOutput($sformatf("clr%0d_we", i), memWe, 1);
            checkOutput($sformatf("clr%0d_waddr", i), memAddrWrite, i);
            checkOutput($sformatf("clr%0d_din", i), memDataIn, 0);
            checkOutput($sformatf("clr%0d_done", i), clearDone, 0);
        end
        applyStimulus(1, 0, 5'd0, '0, 0, 0, '0, '0, 0);
        checkOutput("clr_done_pulse", clearDone, 1);
        checkOutput("clr_done_busy", clearBusy, 0);
        checkOutput("clr_done_agnt", aGnt, 1);
        applyStimulus(1, 0, 5'd17, '0, 0, 0, '0, '0, 0);
        checkOutput("clr_done_once", clearDone, 0);
        checkOutput("clr_rd0", aRdata, 0);
        applyStimulus(1, 0, 5'd31, '0, 0, 0, '0, '0, 0);
        checkOutput("clr_rd17", aRdata, 0);
        idleCycle();
        checkOutput("clr_rd31", aRdata, 0);
        checkOutput("clr_rd31_valid", aRvalid, 1);
        checkOutput("clr_restart_ignored", clearBusy, 0);

        // Reset while the sweep is writing address 10
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1, 5'(i), 16'h5A5A, 0, 0, '0, '0, 0);
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 1);
        for (int i = 0; i <= 10; i++) begin
            idleCycle();
            checkOutput($sformatf("abt%0d_waddr", i), memAddrWrite, i);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        idleCycle();
        checkOutput("abt_busy", clearBusy, 0);
        checkOutput("abt_done", clearDone, 0);
        doneSeen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            idleCycle();
            if (clearDone) doneSeen = 1'b1;
        end
        checkOutput("abt_no_done", doneSeen, 0);
        applyStimulus(1, 0, 5'd11, '0, 1, 0, 5'd12, '0, 0);
        checkOutput("abt_rr_agnt", aGnt, 1);
        checkOutput("abt_rr_bgnt", bGnt, 0);
        applyStimulus(1, 0, 5'd20, '0, 0, 0, '0, '0, 0);
        checkOutput("abt_rd11", aRdata, 16'h5A5A);
        applyStimulus(1, 0, 5'd31, '0, 0, 0, '0, '0, 0);
        checkOutput("abt_rd20", aRdata, 16'h5A5A);
        applyStimulus(1, 0, 5'd9, '0, 0, 0, '0, '0, 0);
        checkOutput("abt_rd31", aRdata, 16'h5A5A);
        idleCycle();
        checkOutput("abt_rd9", aRdata, 0);

        // Clear requested in the same cycle as a B read
        applyStimulus(0, 0, '0, '0, 1, 1, 5'd7, 16'hCAFE, 0);
        applyStimulus(0, 0, '0, '0, 1, 0, 5'd7, '0, 1);
        checkOutput("cs_bgnt", bGnt, 1);
        checkOutput("cs_raddr", memAddrRead, 7);
        idleCycle();
        checkOutput("cs_brvalid", bRvalid, 1);
        checkOutput("cs_brdata", bRdata, 16'hCAFE);
        checkOutput("cs_busy", clearBusy, 1);
        checkOutput("cs_waddr0", memAddrWrite, 0);
        doneSeen = 1'b0;
        for (int i = 0; i < 40 && !doneSeen; i++) begin
            idleCycle();
            if (clearDone) doneSeen = 1'b1;
        end
        checkOutput("cs_done_seen", doneSeen, 1);
        applyStimulus(0, 0, '0, '0, 1, 0, 5'd7, '0, 0);
        idleCycle();
        checkOutput("cs_rd7_valid", bRvalid, 1);
        checkOutput("cs_rd7", bRdata, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
